// File: rtl/stream_concat_fifo_n_if.sv
// Handshake bundle for stream_concat_fifo_n: per-lane input streams plus the wide output stream.
// The slave modport is the concat block's view; master is the producer/sink side.
interface stream_concat_fifo_n_if #(
    parameter int unsigned NUM_STREAMS     = 4,
    parameter int unsigned STREAM_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH_POW2 = 5
);
    logic [NUM_STREAMS-1:0]                     s_tenable;
    logic [NUM_STREAMS-1:0]                     s_tvalid;
    logic [NUM_STREAMS*STREAM_WIDTH-1:0]        s_tdata;
    logic [NUM_STREAMS-1:0]                     s_tready;
    logic                                       s_tlast;
    logic [NUM_STREAMS*(FIFO_DEPTH_POW2+1)-1:0] s_fill;
    logic                                       m_tvalid;
    logic [NUM_STREAMS*STREAM_WIDTH-1:0]        m_tdata;
    logic                                       m_tlast;
    logic                                       m_tready;

    modport master (
        output s_tenable, s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, s_fill, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        input  s_tenable, s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, s_fill, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/stream_concat_fifo_n.sv
// Joins NUM_STREAMS valid/ready lanes, each behind its own FIFO, into one wide beat.
// A beat leaves only when every enabled lane has data; disabled lanes show DISABLED_FILL.
module stream_concat_fifo_n #(
    parameter int unsigned             NUM_STREAMS     = 4,
    parameter int unsigned             STREAM_WIDTH    = 8,
    parameter int unsigned             FIFO_DEPTH_POW2 = 5,
    parameter bit                      REGISTERED_OUT  = 1'b0,
    parameter logic [STREAM_WIDTH-1:0] DISABLED_FILL   = '0
) (
    input logic                   aclk,
    input logic                   reset,
    stream_concat_fifo_n_if.slave bus
);
    localparam int unsigned N     = NUM_STREAMS;
    localparam int unsigned W     = STREAM_WIDTH;
    localparam int unsigned D     = FIFO_DEPTH_POW2;
    localparam int unsigned FW    = D + 1;
    localparam int unsigned Depth = 1 << D;

    logic [D:0]   wr_ptr_q [N];
    logic [D:0]   rd_ptr_q [N];
    logic [W-1:0] mem_q [N][Depth];
    logic         last_mem_q [Depth];

    logic [N-1:0]    full, empty, wr_en, rd_en;
    logic [N*FW-1:0] fill;
    logic [N*W-1:0]  head_data;
    logic            head_last, avail, pop;
    logic            m_tvalid, m_tlast;
    logic [N*W-1:0]  m_tdata;

    always_comb begin
        full      = '0;
        empty     = '0;
        wr_en     = '0;
        fill      = '0;
        head_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            full[i]  = (wr_ptr_q[i][D] != rd_ptr_q[i][D]) &&
                       (wr_ptr_q[i][D-1:0] == rd_ptr_q[i][D-1:0]);
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            wr_en[i] = bus.s_tvalid[i] & ~full[i];
            fill[i*FW +: FW]    = wr_ptr_q[i] - rd_ptr_q[i];
            head_data[i*W +: W] = bus.s_tenable[i] ? mem_q[i][rd_ptr_q[i][D-1:0]]
                                                   : DISABLED_FILL;
        end
        // With no lane enabled the AND term is vacuously true, so gate on any-enabled.
        avail     = (|bus.s_tenable) & (&(~empty | ~bus.s_tenable));
        head_last = bus.s_tenable[0] & last_mem_q[rd_ptr_q[0][D-1:0]];
    end

    assign rd_en = {N{pop}} & bus.s_tenable;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FW'(1);
                if (rd_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + FW'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_en[i]) mem_q[i][wr_ptr_q[i][D-1:0]] <= bus.s_tdata[i*W +: W];
        end
        if (wr_en[0]) last_mem_q[wr_ptr_q[0][D-1:0]] <= bus.s_tlast;
    end

    if (REGISTERED_OUT) begin : g_reg_out
        logic           m_tvalid_q, m_tlast_q;
        logic [N*W-1:0] m_tdata_q;

        assign pop = avail & (~m_tvalid_q | bus.m_tready);

        always_ff @(posedge aclk or posedge reset) begin
            if (reset) begin
                m_tvalid_q <= 1'b0;
                m_tdata_q  <= '0;
                m_tlast_q  <= 1'b0;
            end else if (pop) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= head_data;
                m_tlast_q  <= head_last;
            end else if (bus.m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end

        assign m_tvalid = m_tvalid_q;
        assign m_tdata  = m_tdata_q;
        assign m_tlast  = m_tlast_q;
    end else begin : g_comb_out
        assign pop      = avail & bus.m_tready;
        assign m_tvalid = avail;
        assign m_tdata  = head_data;
        assign m_tlast  = head_last;
    end

    assign bus.s_tready = ~full;
    assign bus.s_fill   = fill;
    assign bus.m_tvalid = m_tvalid;
    assign bus.m_tdata  = m_tdata;
    assign bus.m_tlast  = m_tlast;
endmodule
